// File: rtl/ex_mem_pipe_reg_pkg.sv
// ex_mem_pipe_reg_pkg: shared widths, control-bit indices and payload sizing for the EX/MEM register
package ex_mem_pipe_reg_pkg;
   localparam int CTRL_W         = 5;
   localparam int CTRL_MEMREAD   = 0;
   localparam int CTRL_MEMWRITE  = 1;
   localparam int CTRL_BRANCH    = 2;
   localparam int CTRL_REGWRITE  = 3;
   localparam int CTRL_MEMTOREG  = 4;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   function automatic int payloadW(input int dataW, input int regAddrW);
      return 2 + CTRL_W + 3 * dataW + regAddrW;
   endfunction
endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// ex_mem_pipe_reg_if: EX-side handshake/payload and MEM-side handshake/registered payload
interface ex_mem_pipe_reg_if
   import ex_mem_pipe_reg_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
   logic                  in_valid, in_ready, flush;
   logic                  hit, zeroFlag;
   logic                  MemRead, MemWrite, Branch, RegWrite, MemToReg;
   logic [DATA_W-1:0]     branchTarget, ALUResult, readData2;
   logic [REG_ADDR_W-1:0] writeReg;
   logic                  out_valid, out_ready;
   logic                  hitOut, zeroFlagOut;
   logic                  MemReadOut, MemWriteOut, BranchOut, RegWriteOut, MemToRegOut;
   logic [DATA_W-1:0]     branchTargetOut, ALUResultOut, readData2Out;
   logic [REG_ADDR_W-1:0] writeRegOut;
   modport master (
      output in_valid, flush, hit, zeroFlag, MemRead, MemWrite, Branch, RegWrite, MemToReg,
             branchTarget, ALUResult, readData2, writeReg, out_ready,
      input  in_ready, out_valid, hitOut, zeroFlagOut, MemReadOut, MemWriteOut, BranchOut,
             RegWriteOut, MemToRegOut, branchTargetOut, ALUResultOut, readData2Out, writeRegOut
   );
   modport slave (
      input  in_valid, flush, hit, zeroFlag, MemRead, MemWrite, Branch, RegWrite, MemToReg,
             branchTarget, ALUResult, readData2, writeReg, out_ready,
      output in_ready, out_valid, hitOut, zeroFlagOut, MemReadOut, MemWriteOut, BranchOut,
             RegWriteOut, MemToRegOut, branchTargetOut, ALUResultOut, readData2Out, writeRegOut
   );
endinterface

// File: rtl/ex_mem_pipe_reg_slot.sv
// ex_mem_pipe_reg_slot: one valid bit plus payload register with load and clear controls
module ex_mem_pipe_reg_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);
   // load wins over clear so a slot drained this edge can be refilled; clear keeps the data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM pipeline register with valid/ready, flush, bubble zeroing and optional skid slot
module ex_mem_pipe_reg
   import ex_mem_pipe_reg_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter bit SKID       = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   ex_mem_pipe_reg_if.slave  bus
);
   localparam int PW = payloadW(DATA_W, REG_ADDR_W);
   logic [CTRL_W-1:0] ctrlIn, ctrlOut;
   logic [PW-1:0]     inPayload, mainD, mainQ, skidQ;
   logic              mainValid, skidValid, accept, consume;
   logic              mainLoad, mainClear, skidLoad, skidClear;
   logic              hitQ, zeroQ;
   // gather the control bits into their indexed positions
   always_comb begin
      ctrlIn                = '0;
      ctrlIn[CTRL_MEMREAD]  = bus.MemRead;
      ctrlIn[CTRL_MEMWRITE] = bus.MemWrite;
      ctrlIn[CTRL_BRANCH]   = bus.Branch;
      ctrlIn[CTRL_REGWRITE] = bus.RegWrite;
      ctrlIn[CTRL_MEMTOREG] = bus.MemToReg;
   end
   assign inPayload = {bus.hit, bus.zeroFlag, ctrlIn, bus.branchTarget, bus.ALUResult, bus.readData2, bus.writeReg};
   assign bus.in_ready = SKID ? ~skidValid : (bus.out_ready | ~mainValid);
   assign accept    = bus.in_valid & bus.in_ready & ~bus.flush;
   assign consume   = mainValid & bus.out_ready;
   assign skidLoad  = SKID & accept & mainValid & ~bus.out_ready;
   assign mainLoad  = (accept & ~skidLoad) | (consume & skidValid & ~bus.flush);
   assign mainD     = skidValid ? skidQ : inPayload;
   assign mainClear = bus.flush | consume;
   assign skidClear = bus.flush | consume;
   ex_mem_pipe_reg_slot #(.W(PW)) mainSlot (
      .clk(clk), .rst_n(rst_n), .load(mainLoad), .clear(mainClear), .d(mainD), .valid(mainValid), .q(mainQ)
   );
   ex_mem_pipe_reg_slot #(.W(PW)) skidSlot (
      .clk(clk), .rst_n(rst_n), .load(skidLoad), .clear(skidClear), .d(inPayload), .valid(skidValid), .q(skidQ)
   );
   assign {hitQ, zeroQ, ctrlOut, bus.branchTargetOut, bus.ALUResultOut, bus.readData2Out, bus.writeRegOut} = mainQ;
   assign bus.out_valid   = mainValid;
   assign bus.hitOut      = hitQ & mainValid;
   assign bus.zeroFlagOut = zeroQ & mainValid;
   assign bus.MemReadOut  = ctrlOut[CTRL_MEMREAD] & mainValid;
   assign bus.MemWriteOut = ctrlOut[CTRL_MEMWRITE] & mainValid;
   assign bus.BranchOut   = ctrlOut[CTRL_BRANCH] & mainValid;
   assign bus.RegWriteOut = ctrlOut[CTRL_REGWRITE] & mainValid;
   assign bus.MemToRegOut = ctrlOut[CTRL_MEMTOREG] & mainValid;
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: drives SKID=0 and SKID=1 instances with shared stimulus against queue models
module tb_ex_mem_pipe_reg;
   logic         clk = 1'b0;
   logic         rstN = 1'b0;
   logic         inValid = 1'b0;
   logic         outReady = 1'b0;
   logic         flush = 1'b0;
   logic [107:0] pay = '0;
   logic [107:0] outPay [2];
   logic         inRdy [2];
   logic         outVld [2];
   int           vectors = 0;
   int           miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : lane
      ex_mem_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();
      ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(g == 1)) dut (.clk(clk), .rst_n(rstN), .bus(bus));
      assign bus.in_valid     = inValid;
      assign bus.out_ready    = outReady;
      assign bus.flush        = flush;
      assign bus.hit          = pay[107];
      assign bus.zeroFlag     = pay[106];
      assign bus.MemToReg     = pay[105];
      assign bus.RegWrite     = pay[104];
      assign bus.Branch       = pay[103];
      assign bus.MemWrite     = pay[102];
      assign bus.MemRead      = pay[101];
      assign bus.branchTarget = pay[100:69];
      assign bus.ALUResult    = pay[68:37];
      assign bus.readData2    = pay[36:5];
      assign bus.writeReg     = pay[4:0];
      assign outPay[g] = {bus.hitOut, bus.zeroFlagOut, bus.MemToRegOut, bus.RegWriteOut, bus.BranchOut,
                          bus.MemWriteOut, bus.MemReadOut, bus.branchTargetOut, bus.ALUResultOut,
                          bus.readData2Out, bus.writeRegOut};
      assign inRdy[g]  = bus.in_ready;
      assign outVld[g] = bus.out_valid;

      logic [107:0] sbq [$];
      logic [107:0] last = '0;
      logic [107:0] expPay;
      logic         expRdy;
      bit           seen = 1'b0;
      // mid-cycle: compare DUT state with the model, then apply the transfers of the coming edge
      always @(negedge clk) begin
         if (!rstN) begin
            sbq.delete();
            last = '0;
            seen = 1'b1;
         end else if (seen) begin
            expRdy = (g == 1) ? (sbq.size() < 2) : (outReady || sbq.size() == 0);
            expPay = last;
            if (sbq.size() == 0) expPay[107:101] = '0;
            vectors += 3;
            if (outVld[g] !== (sbq.size() > 0)) begin
               miscompares++;
               $display("FAIL lane%0d out_valid: got %b want %b", g, outVld[g], sbq.size() > 0);
            end
            if (outPay[g] !== expPay) begin
               miscompares++;
               $display("FAIL lane%0d payload: got %h want %h", g, outPay[g], expPay);
            end
            if (inRdy[g] !== expRdy) begin
               miscompares++;
               $display("FAIL lane%0d in_ready: got %b want %b", g, inRdy[g], expRdy);
            end
            if (flush) sbq.delete();
            else begin
               if (outReady && sbq.size() > 0) void'(sbq.pop_front());
               if (inValid && expRdy) sbq.push_back(pay);
            end
            if (sbq.size() > 0) last = sbq[0];
         end
      end
   end

   function automatic logic [107:0] mk(input logic [31:0] alu, input logic [4:0] wr, input logic [6:0] ctl);
      return {ctl, alu ^ 32'h5A5A_0F0F, alu, ~alu, wr};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstN = 1'b0; inValid = 1'b1; outReady = 1'b1; pay = mk(32'hDEADBEEF, 5'd3, 7'h7F);
      repeat (2) cyc();
      for (int g = 0; g < 2; g++) begin
         vectors += 2;
         if (outPay[g] !== '0) begin miscompares++; $display("FAIL reset lane%0d outs: got %h want 0", g, outPay[g]); end
         if (outVld[g] !== 1'b0) begin miscompares++; $display("FAIL reset lane%0d out_valid: got %b want 0", g, outVld[g]); end
      end
      rstN = 1'b1; inValid = 1'b0;
      #1;
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (inRdy[g] !== 1'b1) begin miscompares++; $display("FAIL reset lane%0d in_ready: got %b want 1", g, inRdy[g]); end
      end
   endtask

   task automatic test_stream();
      outReady = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         pay = mk(k, 5'(k), 7'b0011001); inValid = 1'b1;
         cyc();
         for (int g = 0; g < 2; g++) begin
            vectors += 2;
            if (outPay[g][68:37] !== 32'(k)) begin miscompares++; $display("FAIL stream lane%0d alu: got %h want %h", g, outPay[g][68:37], k); end
            if (outVld[g] !== 1'b1) begin miscompares++; $display("FAIL stream lane%0d out_valid: got %b want 1", g, outVld[g]); end
         end
      end
      inValid = 1'b0;
      cyc();
   endtask

   task automatic test_stall();
      outReady = 1'b0; pay = mk(32'h10, 5'd1, 7'b0001000); inValid = 1'b1;
      cyc();
      pay = mk(32'h20, 5'd2, 7'b0000001);
      cyc();
      vectors += 3;
      if (inRdy[1] !== 1'b0) begin miscompares++; $display("FAIL stall skid in_ready: got %b want 0", inRdy[1]); end
      if (inRdy[0] !== 1'b0) begin miscompares++; $display("FAIL stall single in_ready: got %b want 0", inRdy[0]); end
      if (outPay[1][68:37] !== 32'h10) begin miscompares++; $display("FAIL stall hold alu: got %h want 10", outPay[1][68:37]); end
      outReady = 1'b1;
      cyc();
      inValid = 1'b0;
      for (int g = 0; g < 2; g++) begin
         vectors += 2;
         if (outPay[g][68:37] !== 32'h20) begin miscompares++; $display("FAIL stall lane%0d second alu: got %h want 20", g, outPay[g][68:37]); end
         if (outVld[g] !== 1'b1) begin miscompares++; $display("FAIL stall lane%0d second valid: got %b want 1", g, outVld[g]); end
      end
      cyc();
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (outVld[g] !== 1'b0) begin miscompares++; $display("FAIL stall lane%0d drained: got %b want 0", g, outVld[g]); end
      end
   endtask

   task automatic test_flush();
      outReady = 1'b0; pay = mk(32'h55, 5'd4, 7'b0001010); inValid = 1'b1;
      cyc();
      pay = mk(32'h99, 5'd6, 7'b0001010);
      cyc();
      vectors++;
      if (inRdy[1] !== 1'b0) begin miscompares++; $display("FAIL flush full in_ready: got %b want 0", inRdy[1]); end
      flush = 1'b1; pay = mk(32'h77, 5'd7, 7'b0001010);
      cyc();
      flush = 1'b0; inValid = 1'b0;
      for (int g = 0; g < 2; g++) begin
         vectors += 3;
         if (outVld[g] !== 1'b0) begin miscompares++; $display("FAIL flush lane%0d out_valid: got %b want 0", g, outVld[g]); end
         if (outPay[g][107:101] !== 7'h0) begin miscompares++; $display("FAIL flush lane%0d ctrl: got %h want 0", g, outPay[g][107:101]); end
         if (inRdy[g] !== 1'b1) begin miscompares++; $display("FAIL flush lane%0d in_ready: got %b want 1", g, inRdy[g]); end
      end
      outReady = 1'b1;
      repeat (3) begin
         cyc();
         for (int g = 0; g < 2; g++) begin
            vectors++;
            if (outVld[g] !== 1'b0) begin miscompares++; $display("FAIL flush lane%0d ghost entry: got %b want 0", g, outVld[g]); end
         end
      end
   endtask

   task automatic test_bubble();
      outReady = 1'b1; pay = mk(32'h5, 5'd9, 7'b1011010); inValid = 1'b1;
      cyc();
      inValid = 1'b0;
      for (int g = 0; g < 2; g++) begin
         vectors++;
         if (outPay[g][104] !== 1'b1) begin miscompares++; $display("FAIL bubble lane%0d RegWriteOut live: got %b want 1", g, outPay[g][104]); end
      end
      repeat (3) begin
         cyc();
         for (int g = 0; g < 2; g++) begin
            vectors += 3;
            if (outPay[g][104] !== 1'b0) begin miscompares++; $display("FAIL bubble lane%0d RegWriteOut: got %b want 0", g, outPay[g][104]); end
            if (outPay[g][102] !== 1'b0) begin miscompares++; $display("FAIL bubble lane%0d MemWriteOut: got %b want 0", g, outPay[g][102]); end
            if (outPay[g][4:0] !== 5'd9) begin miscompares++; $display("FAIL bubble lane%0d writeRegOut: got %0d want 9", g, outPay[g][4:0]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] r;
      for (int i = 0; i < 400; i++) begin
         r = {$urandom(), $urandom(), $urandom(), $urandom()};
         pay = r[107:0];
         inValid = ($urandom_range(0, 3) != 0);
         outReady = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 19) == 0);
         cyc();
      end
      flush = 1'b0; inValid = 1'b0;
   endtask

   task automatic test_midreset();
      outReady = 1'b0; inValid = 1'b1; pay = mk(32'hAB, 5'd11, 7'h7F);
      repeat (2) cyc();
      rstN = 1'b0; inValid = 1'b0;
      cyc();
      rstN = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         vectors += 3;
         if (outVld[g] !== 1'b0) begin miscompares++; $display("FAIL midreset lane%0d out_valid: got %b want 0", g, outVld[g]); end
         if (outPay[g] !== '0) begin miscompares++; $display("FAIL midreset lane%0d outs: got %h want 0", g, outPay[g]); end
         if (inRdy[g] !== 1'b1) begin miscompares++; $display("FAIL midreset lane%0d in_ready: got %b want 1", g, inRdy[g]); end
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_bubble();
      test_back_to_back();
      test_midreset();
      repeat (2) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
